// File: rtl/mult_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and small op-decode helpers.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_mul(mdop_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic op_is_signed(mdop_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the mult/div unit.
// Handshake: start is a request that is taken on a rising edge only when
// busy=0; once taken, busy stays high until the done cycle, where a new
// start may already be presented for back-to-back issue.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  import mult_div_unit_pkg::*;

  logic             start;
  logic             flush;
  mdop_t            op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  md_state_t        state;

  modport master (
    output start, flush, op, a, b,
    input  busy, done, hi, lo, div_zero, state
  );

  modport slave (
    input  start, flush, op, a, b,
    output busy, done, hi, lo, div_zero, state
  );

endinterface

// File: rtl/mult_div_unit_md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. acc holds {upper half, lower half} of the working register.
module md_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdop_t              op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Partial remainder shifted left with the next dividend bit brought in.
    trial   = acc[2*WIDTH-1:WIDTH-1];
    diff    = trial - {1'b0, opnd};
    acc_nxt = '0;
    if (op_is_mul(op)) begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers. Fixed latency
// of WIDTH+1 edges from an accepted start to the done pulse.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  mult_div_unit_if.slave   md
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t          state, state_nxt;
  logic [CW-1:0]      cnt;
  mdop_t              op_q;
  logic               neg_res_q, neg_rem_q, b_zero_q;
  logic [WIDTH-1:0]   a_raw_q, opb_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, div_zero_q;

  logic               accept, is_sgn;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               write_res;

  assign accept = (state == IDLE) && md.start;
  assign is_sgn = SIGNED_EN && op_is_signed(md.op);
  assign abs_a  = (is_sgn && md.a[WIDTH-1]) ? -md.a : md.a;
  assign abs_b  = (is_sgn && md.b[WIDTH-1]) ? -md.b : md.b;

  md_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .opnd    (opb_q),
    .acc_nxt (acc_step)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (md.start) state_nxt = RUN;
      RUN: begin
        if (md.flush)             state_nxt = IDLE;
        else if (cnt == CW'(1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign correction works on magnitudes; MIN/-1 wraps back to MIN naturally.
  assign prod_fix  = neg_res_q ? -acc_q : acc_q;
  assign quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign write_res = (state == FIX) && !md.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt        <= '0;
      op_q       <= MD_MULT;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      a_raw_q    <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= write_res;
      if (accept) begin
        cnt        <= CW'(WIDTH);
        op_q       <= md.op;
        neg_res_q  <= is_sgn && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
        neg_rem_q  <= is_sgn && md.a[WIDTH-1];
        b_zero_q   <= (md.b == '0);
        a_raw_q    <= md.a;
        opb_q      <= abs_b;
        acc_q      <= {{WIDTH{1'b0}}, abs_a};
        div_zero_q <= 1'b0;
      end else if (state == RUN && !md.flush) begin
        acc_q <= acc_step;
        cnt   <= cnt - CW'(1);
      end
      if (write_res) begin
        if (op_is_mul(op_q)) begin
          hi_q       <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q       <= prod_fix[WIDTH-1:0];
          div_zero_q <= 1'b0;
        end else if (b_zero_q) begin
          hi_q       <= a_raw_q;
          lo_q       <= '1;
          div_zero_q <= 1'b1;
        end else begin
          hi_q       <= rem_fix;
          lo_q       <= quo_fix;
          div_zero_q <= 1'b0;
        end
      end
    end
  end

  assign md.busy     = (state != IDLE);
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.div_zero = div_zero_q;
  assign md.state    = state;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multi-cycle multiply/divide unit with HI/LO result registers, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and serves MULT/MULTU/DIV/DIVU. Results land in HI/LO, and pipeline control stalls on busy. The unit adds behaviour the single-cycle ALU lacks: a start/busy/done handshake, signed and unsigned modes, flush and divide-by-zero reporting.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be at least 4.
SIGNED_EN, 1, when 0 the signed ops are treated as their unsigned counterparts (area-reduced build).

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
flush  input  1  cancel the in-flight operation (pipeline squash)
op  input  2  mdop_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; hi/lo valid from this cycle on
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient
div_zero  output  1  registered with done; set when a divide had b==0

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE; busy, done and div_zero = 0; hi = lo = 0; internal counter, accumulators and operand registers = 0. Reset mid-operation aborts with no done pulse.
- States:
  - IDLE: start=1 latches op, |a|, |b| (absolute values only for signed ops), the result sign flags and b==0. Counter loads WIDTH. Next state is RUN.
  - RUN: one radix-2 step per cycle. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring shift-subtract. The counter decrements; when it reaches 1 the next state is FIX.
  - FIX: applies sign correction and writes hi/lo and div_zero. Sets done=1 for the next cycle. Next state is IDLE.
- Latency: start sampled at edge k, result written and done high after edge k+WIDTH+1. That is 33 edges for WIDTH=32. Latency is fixed and independent of operand values, including b==0.
- Timing of start and busy:
  - busy goes high after edge k and low in the done cycle.
  - A new start is accepted in the done cycle, giving back-to-back issue.
  - start while busy=1 is ignored.
- Signed rules:
  - Product sign = a[W-1]^b[W-1]; negate the 2*WIDTH result.
  - Quotient sign = a^b sign. Remainder takes the dividend's sign.
  - MIN/-1 yields lo = MIN, hi = 0 with no trap.
- Divide by zero:
  - lo = all ones, hi = raw a, div_zero = 1. This holds for signed and unsigned.
  - div_zero is cleared at the next accepted start.
- flush:
  - flush=1 in RUN or FIX: next state is IDLE, and hi/lo/div_zero keep their previous values. No done pulse.
  - flush in IDLE has no effect. Simultaneous flush and start in IDLE accepts start; flush is ignored.
- hi/lo hold between operations; only FIX writes them.

Decomposition:
- cpu_types_pkg gains typedef enum logic[1:0] mdop_t (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3) and md_state_t (IDLE, RUN, FIX).
- Sub-module md_step (combinational) computes one multiply or divide iteration from accumulator and operand. It is reused if a radix-4 variant follows.
- The counter width is the localparam $clog2(WIDTH)+1.

Test Plan:
1. MD_MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> hi=FFFFFFFE lo=00000001. done exactly 33 edges after start; busy high for 33 cycles.
2. MD_MULT a=-3 b=5 -> hi=FFFFFFFF lo=FFFFFFF1. Issue MD_MULTU a=3 b=5 in the done cycle -> accepted; 33 edges later lo=0000000F hi=0.
3. MD_DIV a=-7 b=2 -> lo=FFFFFFFD (-3) hi=FFFFFFFF (-1). MD_DIVU a=7 b=2 -> lo=3 hi=1. MD_DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
4. MD_DIVU a=5 b=0 -> lo=FFFFFFFF hi=00000005 div_zero=1, same 33-edge latency. Next valid start clears div_zero.
5. Start MD_MULTU 2*3, raise flush at RUN cycle 10 -> busy low next cycle, no done, hi/lo unchanged. Pulse start with different operands while busy -> no effect on the result.
6. nRST low mid-RUN -> busy/done/hi/lo = 0 immediately without a clock edge. After release, a fresh MD_MULT 4*4 gives lo=16.
